// File: rtl/intc_pkg.sv
// Shared types and register map for the interrupt controller.
// The optional INTC_EDGE_DETECT_EN feature is handled in interrupt_controller.sv.
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_t;

    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_VECTOR  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_EOI     = 3'd4;
    localparam logic [2:0] REG_RAW     = 3'd5;
    localparam int         NUM_REGS    = 6;

    // Vector width; a single source still needs one bit
    function automatic int vec_w(input int sources);
        return (sources > 1) ? $clog2(sources) : 1;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational lowest-index-wins encoder: index 0 has the highest priority.
module priority_encoder
    import intc_pkg::*;
#(
    parameter int SOURCES = 8
) (
    input  logic [SOURCES-1:0]         req,
    output logic                       valid,
    output logic [vec_w(SOURCES)-1:0]  index
);

    localparam int VW = vec_w(SOURCES);

    always_comb begin
        valid = |req;
        index = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (req[i]) index = VW'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Register-mapped interrupt controller: pending latch, mask, priority select, IDLE/REQUEST/SERVICE.
// Define INTC_EDGE_DETECT_EN to latch only rising edges of interrupt_i (one cycle extra latency).
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int SOURCES = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [SOURCES-1:0]         interrupt_i,
    input  logic                       write_i,
    input  logic [31:0]                write_data_i,
    input  logic [2:0]                 write_address_i,
    output logic                       write_error_o,
    input  logic                       read_i,
    input  logic [2:0]                 read_address_i,
    output logic [31:0]                read_data_o,
    output logic                       read_error_o,
    output logic                       interrupt_o,
    output logic [vec_w(SOURCES)-1:0]  interrupt_vector_o,
    input  logic                       acknowledge_i
);

    localparam int VW = vec_w(SOURCES);

    intc_state_t        state_q, next_state;
    logic [SOURCES-1:0] enable_q;
    logic [SOURCES-1:0] pending_q;
    logic               gie_q;
    logic [VW-1:0]      vector_q;
    logic [SOURCES-1:0] src_event;
    logic [SOURCES-1:0] ack_mask;
    logic [SOURCES-1:0] w1c_mask;
    logic               enc_valid;
    logic [VW-1:0]      enc_index;
    logic               ack_take;
    logic               load_vec;
    logic               eoi_wr;
    logic               unused_wdata;

    assign unused_wdata = ^write_data_i;

`ifdef INTC_EDGE_DETECT_EN
    logic [SOURCES-1:0] irq_q, irq_qq;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q  <= '0;
            irq_qq <= '0;
        end else begin
            irq_q  <= interrupt_i;
            irq_qq <= irq_q;
        end
    end

    assign src_event = irq_q & ~irq_qq;
`else
    assign src_event = interrupt_i;
`endif

    priority_encoder #(.SOURCES(SOURCES)) u_prio (
        .req   (pending_q & enable_q),
        .valid (enc_valid),
        .index (enc_index)
    );

    assign eoi_wr   = write_i && (write_address_i == REG_EOI);
    assign w1c_mask = (write_i && (write_address_i == REG_PENDING)) ? write_data_i[SOURCES-1:0] : '0;

    always_comb begin
        ack_mask = '0;
        ack_mask[vector_q] = ack_take;
    end

    always_comb begin
        next_state = state_q;
        ack_take   = 1'b0;
        load_vec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && enc_valid) begin
                    next_state = ST_REQUEST;
                    load_vec   = 1'b1;
                end
            end
            ST_REQUEST: begin
                // Masking the source does not withdraw; only ack or global disable leave REQUEST
                if (acknowledge_i) begin
                    ack_take   = 1'b1;
                    next_state = ST_SERVICE;
                end else if (!gie_q) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            enable_q  <= '0;
            pending_q <= '0;
            gie_q     <= 1'b0;
            vector_q  <= '0;
        end else begin
            state_q <= next_state;
            // New events win over same-cycle clears so no interrupt is lost
            pending_q <= (pending_q & ~w1c_mask & ~ack_mask) | src_event;
            if (load_vec) vector_q <= enc_index;
            if (write_i && (write_address_i == REG_ENABLE)) enable_q <= write_data_i[SOURCES-1:0];
            if (write_i && (write_address_i == REG_CONTROL)) gie_q <= write_data_i[0];
        end
    end

    assign interrupt_o        = (state_q == ST_REQUEST);
    assign interrupt_vector_o = vector_q;
    assign write_error_o      = write_i && (write_address_i > REG_RAW);
    assign read_error_o       = read_i && (read_address_i > REG_RAW);

    always_comb begin
        read_data_o = '0;
        case (read_address_i)
            REG_ENABLE:  read_data_o = 32'(enable_q);
            REG_PENDING: read_data_o = 32'(pending_q);
            REG_VECTOR:  read_data_o = 32'({state_q == ST_SERVICE, vector_q});
            REG_CONTROL: read_data_o = 32'(gie_q);
            REG_RAW:     read_data_o = 32'(interrupt_i);
            default:     read_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller (default build, SOURCES=8): directed cases + random traffic.
module tb_interrupt_controller;

    logic        clk;
    logic        rst_i;
    logic [7:0]  interrupt_i;
    logic        write_i;
    logic [31:0] write_data_i;
    logic [2:0]  write_address_i;
    logic        write_error_o;
    logic        read_i;
    logic [2:0]  read_address_i;
    logic [31:0] read_data_o;
    logic        read_error_o;
    logic        interrupt_o;
    logic [2:0]  interrupt_vector_o;
    logic        acknowledge_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: mode 0 waiting, 1 requesting, 2 in service
    logic [7:0] m_en, m_pend;
    logic       m_gie;
    int         m_mode;
    int         m_vec;
    logic [31:0] last_rd;

    interrupt_controller #(.SOURCES(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .interrupt_i        (interrupt_i),
        .write_i            (write_i),
        .write_data_i       (write_data_i),
        .write_address_i    (write_address_i),
        .write_error_o      (write_error_o),
        .read_i             (read_i),
        .read_address_i     (read_address_i),
        .read_data_o        (read_data_o),
        .read_error_o       (read_error_o),
        .interrupt_o        (interrupt_o),
        .interrupt_vector_o (interrupt_vector_o),
        .acknowledge_i      (acknowledge_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [7:0] raw);
        case (a)
            3'd0: return {24'd0, m_en};
            3'd1: return {24'd0, m_pend};
            3'd2: return ((m_mode == 2) ? 32'd8 : 32'd0) + 32'(m_vec);
            3'd3: return {31'd0, m_gie};
            3'd5: return {24'd0, raw};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_gie = 1'b0; m_mode = 0; m_vec = 0;
    endtask

    task automatic model_step(input logic [7:0] irq, input bit wr, input logic [2:0] wa,
                              input logic [31:0] wd, input bit ack);
        logic [7:0] np;
        int nm;
        np = m_pend;
        nm = m_mode;
        if (wr && wa == 3'd1) np = np & ~wd[7:0];
        if (m_mode == 0) begin
            if (m_gie && (m_pend & m_en) != 0) begin
                nm = 1;
                m_vec = lowest(m_pend & m_en);
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                nm = 2;
                np[m_vec] = 1'b0;
            end else if (!m_gie) nm = 0;
        end else begin
            if (wr && wa == 3'd4) nm = 0;
        end
        np = np | irq;
        if (wr && wa == 3'd0) m_en = wd[7:0];
        if (wr && wa == 3'd3) m_gie = wd[0];
        m_pend = np;
        m_mode = nm;
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, then check registered outputs after the edge
    task automatic cycle(input logic [7:0] irq, input bit wr, input logic [2:0] wa, input logic [31:0] wd,
                         input bit rd, input logic [2:0] ra, input bit ack);
        @(negedge clk);
        interrupt_i = irq; write_i = wr; write_address_i = wa; write_data_i = wd;
        read_i = rd; read_address_i = ra; acknowledge_i = ack;
        #1;
        chk("wr_err", {31'd0, write_error_o}, {31'd0, wr && (wa > 3'd5)});
        chk("rd_err", {31'd0, read_error_o}, {31'd0, rd && (ra > 3'd5)});
        last_rd = read_data_o;
        if (rd) chk("rdata", read_data_o, model_read(ra, irq));
        @(posedge clk);
        model_step(irq, wr, wa, wd, ack);
        #1;
        chk("irq_o", {31'd0, interrupt_o}, {31'd0, m_mode == 1});
        if (m_mode == 1) chk("vec_o", {29'd0, interrupt_vector_o}, 32'(m_vec));
    endtask

    task automatic idle();                                         cycle(8'h00, 0, 3'd0, 32'd0, 0, 3'd0, 0); endtask
    task automatic wreg(input logic [2:0] a, input logic [31:0] d); cycle(8'h00, 1, a, d, 0, 3'd0, 0);      endtask
    task automatic rreg(input logic [2:0] a);                       cycle(8'h00, 0, 3'd0, 32'd0, 1, a, 0);  endtask
    task automatic pulse(input logic [7:0] m);                      cycle(m, 0, 3'd0, 32'd0, 0, 3'd0, 0);   endtask
    task automatic ack();                                           cycle(8'h00, 0, 3'd0, 32'd0, 0, 3'd0, 1); endtask

    initial begin
        logic [7:0]  r_irq;
        logic [31:0] r_wd;
        logic [2:0]  r_wa;
        bit          r_wr, r_rd, r_ack;

        rst_i = 1'b1;
        interrupt_i = '0; write_i = 0; write_data_i = '0; write_address_i = '0;
        read_i = 0; read_address_i = '0; acknowledge_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        read_i = 1; read_address_i = 3'd1;
        #1;
        chk("rst_irq", {31'd0, interrupt_o}, 32'd0);
        chk("rst_vec", {29'd0, interrupt_vector_o}, 32'd0);
        chk("rst_pend", read_data_o, 32'd0);
        read_i = 0;
        rst_i = 1'b0;

        // Single source, enable 0x04
        wreg(3'd0, 32'h04);
        wreg(3'd3, 32'h1);
        pulse(8'h04);
        idle();
        chk("t1_irq", {31'd0, interrupt_o}, 32'd1);
        chk("t1_vec", {29'd0, interrupt_vector_o}, 32'd2);
        ack();
        rreg(3'd1);
        chk("t1_pend", last_rd, 32'h0);
        rreg(3'd2);
        chk("t1_vreg", last_rd, 32'h0A);
        wreg(3'd4, 32'h0);

        // Simultaneous sources, lowest index first
        wreg(3'd0, 32'hFF);
        pulse(8'h22);
        idle();
        chk("t2_vec1", {29'd0, interrupt_vector_o}, 32'd1);
        ack();
        wreg(3'd4, 32'h0);
        idle();
        chk("t2_irq5", {31'd0, interrupt_o}, 32'd1);
        chk("t2_vec5", {29'd0, interrupt_vector_o}, 32'd5);
        ack();
        wreg(3'd4, 32'h0);

        // Masked source stays pending until enabled
        wreg(3'd0, 32'h00);
        pulse(8'h08);
        rreg(3'd1);
        chk("t3_pend", last_rd, 32'h08);
        chk("t3_noirq", {31'd0, interrupt_o}, 32'd0);
        wreg(3'd0, 32'h08);
        idle();
        chk("t3_vec", {29'd0, interrupt_vector_o}, 32'd3);
        ack();
        wreg(3'd4, 32'h0);

        // W1C colliding with a new event keeps the bit
        cycle(8'h01, 1, 3'd1, 32'h01, 0, 3'd0, 0);
        rreg(3'd1);
        chk("t4_keep", last_rd, 32'h01);
        wreg(3'd1, 32'h01);
        rreg(3'd1);
        chk("t4_clr", last_rd, 32'h00);

        // Global disable withdraws the request, pending untouched
        wreg(3'd0, 32'h10);
        pulse(8'h10);
        idle();
        chk("t5_req", {31'd0, interrupt_o}, 32'd1);
        wreg(3'd3, 32'h0);
        idle();
        chk("t5_drop", {31'd0, interrupt_o}, 32'd0);
        rreg(3'd1);
        chk("t5_pend", last_rd, 32'h10);
        wreg(3'd3, 32'h1);
        idle();
        chk("t5_vec4", {29'd0, interrupt_vector_o}, 32'd4);

        // Asynchronous reset in the middle of a request
        @(negedge clk);
        rst_i = 1'b1;
        model_reset();
        read_i = 1; read_address_i = 3'd1;
        #1;
        chk("t5_rirq", {31'd0, interrupt_o}, 32'd0);
        chk("t5_rvec", {29'd0, interrupt_vector_o}, 32'd0);
        chk("t5_rpend", read_data_o, 32'd0);
        read_address_i = 3'd0;
        #1;
        chk("t5_ren", read_data_o, 32'd0);
        read_i = 0;
        @(negedge clk);
        rst_i = 1'b0;

        // Out-of-range addresses
        wreg(3'd0, 32'h5A);
        cycle(8'h00, 1, 3'd6, 32'hFFFF_FFFF, 1, 3'd7, 0);
        chk("t6_rd7", last_rd, 32'd0);
        cycle(8'h00, 1, 3'd7, 32'hFFFF_FFFF, 1, 3'd6, 0);
        chk("t6_rd6", last_rd, 32'd0);
        rreg(3'd0);
        chk("t6_en", last_rd, 32'h5A);

        // Random traffic against the model
        wreg(3'd3, 32'h1);
        for (int n = 0; n < 3000; n++) begin
            r_irq = '0;
            for (int b = 0; b < 8; b++) r_irq[b] = ($urandom_range(0, 9) == 0);
            r_wr  = ($urandom_range(0, 4) == 0);
            r_wa  = 3'($urandom_range(0, 7));
            r_wd  = $urandom;
            if (r_wa == 3'd3 && $urandom_range(0, 4) != 0) r_wd[0] = 1'b1;
            r_rd  = ($urandom_range(0, 2) != 0);
            r_ack = ($urandom_range(0, 2) == 0);
            cycle(r_irq, r_wr, r_wa, r_wd, r_rd, 3'($urandom_range(0, 7)), r_ack);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
